blake2_block_loader: RTL and testbench
======================================

BLAKE2_BLOCK_LOADER -- requirements
Module: blake2_block_loader

Interface
REQ-001 SHALL have parameter W, default 64, meaning word width in bits (64 for b, 32 for s).
REQ-002 SHALL have parameter BB, default 128, meaning block size in bytes (W*16/8).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port valid_i, input, 1, upstream word valid.
REQ-006 SHALL have port data_i, input, W, message word; byte 0 in bits 7:0 (little-endian).
REQ-007 SHALL have port last_i, input, 1, the current word is the final word of the message.
REQ-008 SHALL have port bytes_i, input, $clog2(W/8)+1, count of valid bytes in the word (0..W/8); only sampled when last_i=1, otherwise W/8 is implied.
REQ-009 SHALL have port ready_o, output, 1, the loader accepts a word this cycle.
REQ-010 SHALL have port valid_o, output, 1, single-cycle pulse; block presented to the compression core.
REQ-011 SHALL have port data_o, output, W*16, padded block; word k at bits [W*k+W-1:W*k].
REQ-012 SHALL have port len_o, output, 2*W, total message length ll in bytes.
REQ-013 SHALL have port hash_v_i, input, 1, hash-valid returned by the compression core.
REQ-014 SHALL have port err_o, output, 1, sticky oversize-message flag.

Function
REQ-015 SHALL transfer a word only on a cycle where valid_i and ready_o are both 1.
REQ-016 SHALL implement the FSM states IDLE, FILL, DRAIN, SEND and WAIT.
- IDLE: ready_o=1; first accepted word -> FILL, or -> SEND if last_i.
- FILL: ready_o=1; accepted word with last_i -> SEND; 16th word without last_i -> DRAIN.
- DRAIN: ready_o=1; words are discarded; accepted last_i -> IDLE; no valid_o is issued.
- SEND: ready_o=0; valid_o=1 for exactly one cycle -> WAIT.
- WAIT: ready_o=0; hash_v_i=1 -> IDLE.
REQ-017 SHALL keep a word index counter 0..15, stored in 4 bits; the accepted word is written at word slot idx, and idx increments on every accept in IDLE/FILL.
REQ-018 SHALL force to zero the bytes at positions >= bytes_i in the last word, and all words after it (zero padding).
REQ-019 SHALL compute len_o = idx*(W/8) + bytes_i for the last word, zero-extended to 2*W bits.
REQ-020 SHALL assert valid_o in the cycle immediately after the last word is accepted (latency 1), and SHALL hold data_o/len_o stable from SEND through WAIT.
REQ-021 SHALL accept a zero-length message (first word with last_i=1, bytes_i=0): data_o all zero, len_o=0.
REQ-022 SHALL treat last_i on word 16 (idx=15) as a legal full block: bytes_i=W/8 gives len_o=BB.
REQ-023 SHALL set err_o on entry to DRAIN; err_o clears only on reset.
REQ-024 SHALL ignore hash_v_i in every state except WAIT.
REQ-025 SHALL ignore valid_i, last_i and bytes_i while ready_o=0.
REQ-026 SHALL treat bytes_i > W/8 as W/8.

Reset
REQ-027 SHALL, on reset=1 at a rising edge, enter IDLE, clear idx, data_o, len_o, valid_o and err_o to 0, and drive ready_o=1 in the following cycle.
REQ-028 SHALL let reset take priority in any state, including mid-FILL and WAIT; a partially loaded block is discarded and no valid_o is issued.

Verification
REQ-029 Bench SHALL cover a 128-byte message (16 words 0x0706050403020100+k*0x0808080808080808, last on word 16, bytes_i=8) -> one valid_o pulse 1 cycle later, len_o=128, data_o bytes 0x00..0x7F in order.
REQ-030 Bench SHALL cover a 3-byte message "abc" (data_i=0x0000000000636261, last_i=1, bytes_i=3) -> data_o[23:0]=0x636261, rest zero, len_o=3; ready_o=0 until hash_v_i.
REQ-031 Bench SHALL cover a zero-length message (last_i=1, bytes_i=0, data_i=all ones) -> data_o=0, len_o=0, valid_o pulse.
REQ-032 Bench SHALL cover an oversize message (17 words, last on word 17) -> no valid_o, err_o=1 from the cycle after word 16, FSM back in IDLE (ready_o=1) after word 17.
REQ-033 Bench SHALL cover reset asserted after 5 words, then a 10-byte message -> only one valid_o pulse, len_o=10, no residue from the aborted words.
REQ-034 Bench SHALL cover a hash_v_i pulse in IDLE and FILL, plus valid_i held high during WAIT -> no state change, no words accepted until hash_v_i arrives in WAIT.

Source files
------------

// File: rtl/blake2_block_loader.sv
// ---------------------------------------------------------------------------
// blake2_block_loader
//
// Collects little-endian message words into one BLAKE2 compression block,
// zero-pads the tail, and presents the block plus the total message length
// to the compression core. Messages longer than one block are drained and
// flagged rather than forwarded.
//
// Ports
//   clk       : clock, all logic on the rising edge
//   reset     : synchronous active-high reset
//   valid_i   : upstream word valid
//   data_i    : message word, byte 0 in bits 7:0
//   last_i    : current word is the final word of the message
//   bytes_i   : valid bytes in the final word (0..W/8), sampled with last_i
//   ready_o   : loader accepts a word this cycle
//   valid_o   : one-cycle pulse, block presented to the core
//   data_o    : padded block, word k at bits [W*k+W-1:W*k]
//   len_o     : total message length in bytes
//   hash_v_i  : hash-valid from the compression core, releases the block
//   err_o     : sticky oversize-message flag
// ---------------------------------------------------------------------------
module blake2_block_loader #(
    parameter int W  = 64,
    parameter int BB = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic [W-1:0]         data_i,
    input  logic                 last_i,
    input  logic [$clog2(W/8):0] bytes_i,
    output logic                 ready_o,
    output logic                 valid_o,
    output logic [W*16-1:0]      data_o,
    output logic [2*W-1:0]       len_o,
    input  logic                 hash_v_i,
    output logic                 err_o
);

    localparam int NB  = W / 8;            // bytes per word
    localparam int BCW = $clog2(NB) + 1;   // width of the byte count
    localparam int LW  = 2 * W;            // width of the length field

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN,
        S_SEND,
        S_WAIT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_idx;
    logic [BB*8-1:0]  r_data;
    logic [LW-1:0]    r_len;
    logic             r_err;

    logic             w_ready;
    logic             w_accept;
    logic             w_load;
    logic [BCW-1:0]   w_bytes;
    logic [W-1:0]     w_word;
    logic [LW-1:0]    w_len;

    // Only the three loading states take words; SEND/WAIT hold the block.
    assign w_ready  = (r_state == S_IDLE) || (r_state == S_FILL) || (r_state == S_DRAIN);
    assign w_accept = valid_i && w_ready;
    // Words accepted in DRAIN are discarded, so only IDLE/FILL store them.
    assign w_load   = w_accept && ((r_state == S_IDLE) || (r_state == S_FILL));

    // Out-of-range byte counts saturate to a full word.
    assign w_bytes  = (bytes_i > BCW'(NB)) ? BCW'(NB) : bytes_i;
    assign w_len    = LW'(r_idx) * LW'(NB) + LW'(w_bytes);

    // Zero every byte at or beyond the valid count of the final word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_word = '0;
        for (int b = 0; b < NB; b++) begin
            if (!last_i || (BCW'(b) < w_bytes)) begin
                w_word[8*b +: 8] = data_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = last_i ? S_SEND : S_FILL;
                end
            end
            S_FILL: begin
                if (w_accept) begin
                    if (last_i) begin
                        w_next = S_SEND;
                    end else if (r_idx == 4'd15) begin
                        w_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_accept && last_i) begin
                    w_next = S_IDLE;
                end
            end
            S_SEND: begin
                valid_o = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                if (hash_v_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the block buffer is cleared on reset because its contents are a visible output.
            r_idx  <= '0;
            r_data <= '0;
            r_len  <= '0;
            r_err  <= 1'b0;
        end else if (w_load) begin
            // A new message starts from an all-zero block, which supplies the
            // padding for every slot that is never written.
            if (r_state == S_IDLE) begin
                r_data <= '0;
            end
            r_data[r_idx*W +: W] <= w_word;
            if (last_i) begin
                r_idx <= '0;
                r_len <= w_len;
            end else begin
                // Wraps to 0 on the 16th word, ready for the next message.
                r_idx <= r_idx + 4'd1;
                if ((r_state == S_FILL) && (r_idx == 4'd15)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign ready_o = w_ready;
    assign data_o  = r_data;
    assign len_o   = r_len;
    assign err_o   = r_err;

endmodule

// File: tb/tb_blake2_block_loader.sv
module tb_blake2_block_loader;

    logic          clk;
    logic          reset;
    logic          valid_i;
    logic [63:0]   data_i;
    logic          last_i;
    logic [3:0]    bytes_i;
    logic          ready_o;
    logic          valid_o;
    logic [1023:0] data_o;
    logic [127:0]  len_o;
    logic          hash_v_i;
    logic          err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulse = 0;

    logic [1023:0] exp_blk;

    blake2_block_loader #(.W(64), .BB(128)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .last_i   (last_i),
        .bytes_i  (bytes_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .len_o    (len_o),
        .hash_v_i (hash_v_i),
        .err_o    (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // valid_o is stable across the low phase, so each SEND cycle counts once.
    always @(negedge clk) begin
        if (valid_o) n_pulse++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_block(input string tag, input logic [1023:0] exp);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s_w%0d", tag, k), 128'(data_o[64*k +: 64]), 128'(exp[64*k +: 64]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic l, input logic [3:0] b);
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        bytes_i = b;
        tick();
        valid_i = 1'b0;
        last_i  = 1'b0;
        bytes_i = 4'd0;
    endtask

    // SEND -> WAIT -> hash_v_i -> IDLE
    task automatic release_block(input string tag);
        tick();
        check({tag, "_wait_valid"}, 128'(valid_o), 128'(0));
        check({tag, "_wait_ready"}, 128'(ready_o), 128'(0));
        hash_v_i = 1'b1;
        tick();
        hash_v_i = 1'b0;
        check({tag, "_idle_ready"}, 128'(ready_o), 128'(1));
    endtask

    initial begin
        int p0;
        reset    = 1'b1;
        valid_i  = 1'b0;
        data_i   = '0;
        last_i   = 1'b0;
        bytes_i  = '0;
        hash_v_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_ready", 128'(ready_o), 128'(1));
        check("rst_valid", 128'(valid_o), 128'(0));
        check("rst_len",   len_o, 128'(0));
        check("rst_err",   128'(err_o), 128'(0));
        check_block("rst_data", '0);

        // hash_v_i in IDLE is ignored
        hash_v_i = 1'b1;
        tick();
        hash_v_i = 1'b0;
        check("idle_hash_ready", 128'(ready_o), 128'(1));
        check("idle_hash_valid", 128'(valid_o), 128'(0));

        // 128-byte message, last on word 16
        p0 = n_pulse;
        for (int k = 0; k < 16; k++) begin
            push(64'h0706050403020100 + 64'(k) * 64'h0808080808080808, (k == 15), 4'd8);
        end
        for (int i = 0; i < 128; i++) exp_blk[8*i +: 8] = 8'(i);
        check("full_valid", 128'(valid_o), 128'(1));
        check("full_len",   len_o, 128'(128));
        check_block("full_data", exp_blk);
        release_block("full");
        check("full_pulses", 128'(n_pulse - p0), 128'(1));

        // "abc", then valid_i held high through WAIT
        p0 = n_pulse;
        push(64'h0000000000636261, 1'b1, 4'd3);
        exp_blk = '0;
        exp_blk[23:0] = 24'h636261;
        check("abc_valid", 128'(valid_o), 128'(1));
        check("abc_ready", 128'(ready_o), 128'(0));
        check("abc_len",   len_o, 128'(3));
        check_block("abc_data", exp_blk);
        valid_i = 1'b1;
        data_i  = 64'hFFFF_FFFF_FFFF_FFFF;
        last_i  = 1'b1;
        bytes_i = 4'd8;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("abc_hold_ready%0d", c), 128'(ready_o), 128'(0));
        end
        hash_v_i = 1'b1;
        tick();
        hash_v_i = 1'b0;
        valid_i  = 1'b0;
        last_i   = 1'b0;
        check("abc_rel_ready", 128'(ready_o), 128'(1));
        check("abc_rel_valid", 128'(valid_o), 128'(0));
        check("abc_rel_len",   len_o, 128'(3));
        check_block("abc_hold", exp_blk);
        check("abc_pulses", 128'(n_pulse - p0), 128'(1));

        // Zero-length message
        p0 = n_pulse;
        push(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
        check("zero_valid", 128'(valid_o), 128'(1));
        check("zero_len",   len_o, 128'(0));
        check_block("zero_data", '0);
        release_block("zero");
        check("zero_pulses", 128'(n_pulse - p0), 128'(1));

        // hash_v_i in FILL ignored; 8 + 2 bytes
        p0 = n_pulse;
        push(64'h1122334455667788, 1'b0, 4'd0);
        hash_v_i = 1'b1;
        tick();
        hash_v_i = 1'b0;
        check("fill_hash_ready", 128'(ready_o), 128'(1));
        check("fill_hash_valid", 128'(valid_o), 128'(0));
        push(64'hFFFF_FFFF_FFFF_CCDD, 1'b1, 4'd2);
        exp_blk = '0;
        exp_blk[63:0]   = 64'h1122334455667788;
        exp_blk[127:64] = 64'h000000000000CCDD;
        check("fill_valid", 128'(valid_o), 128'(1));
        check("fill_len",   len_o, 128'(10));
        check_block("fill_data", exp_blk);
        release_block("fill");
        check("fill_pulses", 128'(n_pulse - p0), 128'(1));

        // bytes_i above a full word saturates to 8
        push(64'h0123456789ABCDEF, 1'b1, 4'd15);
        exp_blk = '0;
        exp_blk[63:0] = 64'h0123456789ABCDEF;
        check("sat_len", len_o, 128'(8));
        check_block("sat_data", exp_blk);
        release_block("sat");

        // Oversize: 17 words
        p0 = n_pulse;
        for (int k = 0; k < 15; k++) push(64'(k), 1'b0, 4'd0);
        check("over_err15", 128'(err_o), 128'(0));
        push(64'd15, 1'b0, 4'd0);
        check("over_err16",   128'(err_o), 128'(1));
        check("over_ready16", 128'(ready_o), 128'(1));
        check("over_valid16", 128'(valid_o), 128'(0));
        push(64'd16, 1'b1, 4'd8);
        check("over_ready17", 128'(ready_o), 128'(1));
        check("over_valid17", 128'(valid_o), 128'(0));
        check("over_err17",   128'(err_o), 128'(1));
        tick();
        check("over_pulses", 128'(n_pulse - p0), 128'(0));
        check("over_err_sticky", 128'(err_o), 128'(1));

        // Reset mid-FILL, then a 10-byte message
        for (int k = 0; k < 5; k++) push(64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 4'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_ready", 128'(ready_o), 128'(1));
        check("rst2_err",   128'(err_o), 128'(0));
        check("rst2_len",   len_o, 128'(0));
        check_block("rst2_data", '0);
        p0 = n_pulse;
        push(64'h8877665544332211, 1'b0, 4'd0);
        push(64'hFFFF_FFFF_FFFF_AABB, 1'b1, 4'd2);
        exp_blk = '0;
        exp_blk[63:0]   = 64'h8877665544332211;
        exp_blk[127:64] = 64'h000000000000AABB;
        check("rst2_valid",   128'(valid_o), 128'(1));
        check("rst2_len10",   len_o, 128'(10));
        check_block("rst2_msg", exp_blk);
        release_block("rst2");
        check("rst2_pulses", 128'(n_pulse - p0), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
